// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder, STEP bits per clock, registered carry.
// Optional subtraction with SERIAL_ADDER_SUB_EN.
`timescale 1ns/1ps

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_ovf
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  // acc_q starts as operand A and fills with sum digits from the top,
  // so after N digits it holds the complete result.
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic [STEP:0]    c_w;
  logic [STEP-1:0]  dsum;
  logic             last;
  logic             sub_w;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_w = i_sub;
`else
  assign sub_w = 1'b0;
`endif

  // Subtraction is A + ~B + 1.
  assign b_in = i_b ^ {WIDTH{sub_w}};
  assign c_in = sub_w | i_c;

  assign c_w[0] = carry_q;

  for (genvar i = 0; i < STEP; i++) begin : g_fa
    logic p;
    assign p         = acc_q[i] ^ b_q[i];
    assign dsum[i]   = p ^ c_w[i];
    assign c_w[i+1]  = (acc_q[i] & b_q[i]) | (c_w[i] & p);
  end

  if (STEP < WIDTH) begin : g_shift
    assign acc_d = {dsum, acc_q[WIDTH-1:STEP]};
  end else begin : g_whole
    assign acc_d = dsum;
  end

  assign last = (cnt_q == CW'(N - 1));

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (i_start) state_d = S_RUN;
      S_RUN:  if (last) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    unique case (1'b1)
      (state_q == S_RUN):  o_busy = 1'b1;
      (state_q == S_DONE): begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand capture, digit processing and result update.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc_q   <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      o_sum   <= '0;
      o_carry <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            acc_q   <= i_a;
            b_q     <= b_in;
            carry_q <= c_in;
            cnt_q   <= '0;
          end
        end
        S_RUN: begin
          acc_q   <= acc_d;
          b_q     <= b_q >> STEP;
          carry_q <= c_w[STEP];
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            o_sum   <= acc_d;
            o_carry <= c_w[STEP];
            o_ovf   <= c_w[STEP] ^ c_w[STEP-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder built from the team's full-adder cell. It adds two `WIDTH`-bit operands plus a carry-in, processing `STEP` bits per clock through a `STEP`-deep ripple of full adders, with a registered carry between digits. It is used where a wide combinational carry chain is too slow or too large. It adds a start/busy/done handshake, carry-out and signed-overflow outputs, and optional subtraction.

## Interface
- `WIDTH`, 8: operand and result width in bits. Must be ≥ 2.
- `STEP`, 1: bits processed per clock. Must divide `WIDTH` exactly.
- `N` (localparam) = `WIDTH/STEP`: number of digit cycles.

- `i_clk`  in  1  clock; everything is updated on the rising edge.
- `i_rst_n`  in  1  reset, synchronous and active-low.
- `i_start`  in  1  start request; sampled only in IDLE.
- `i_a`  in  WIDTH  operand A; captured on an accepted start.
- `i_b`  in  WIDTH  operand B; captured on an accepted start.
- `i_c`  in  1  carry-in; captured on an accepted start.
- `i_sub`  in  1  subtract mode; captured on an accepted start. Exists only with `SERIAL_ADDER_SUB_EN`.
- `o_busy`  out  1  high in RUN and DONE.
- `o_done`  out  1  one-cycle pulse: the result is updated.
- `o_sum`  out  WIDTH  result.
- `o_carry`  out  1  carry out of the MSB.
- `o_ovf`  out  1  signed overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- State machine: IDLE → RUN → DONE → IDLE.
- IDLE, with `i_start` = 1 at an edge:
  - load the A and B shift registers from `i_a` and `i_b`;
  - load the carry register from `i_c`;
  - clear the digit counter;
  - go to RUN.
- IDLE, with `i_start` = 0: remain in IDLE.
- RUN, each edge:
  - add the low `STEP` bits of A and B plus the carry register through the full-adder ripple;
  - store the carry out of the ripple;
  - shift A and B right by `STEP`;
  - shift the digit sum into the top of the internal result register;
  - increment the counter.
- RUN, on the edge that processes digit `N-1`:
  - load `o_sum` with the full result;
  - load `o_carry` with the final carry;
  - load `o_ovf` with (carry into bit `WIDTH-1`) XOR (carry out of bit `WIDTH-1`);
  - set `o_done` = 1;
  - go to DONE.
- DONE: the next edge clears `o_done` and returns to IDLE unconditionally.
- `i_start` in RUN or DONE is ignored, not queued.
- Operand inputs may change freely after an accepted start; only the captured values are used.
- `o_sum`, `o_carry` and `o_ovf` hold their value between completions. The internal shift registers are never visible on the outputs.
- Arithmetic is modulo 2^WIDTH. `o_carry` is the (WIDTH+1)-th bit.

## Timing
- Reset (`i_rst_n` = 0 at an edge), in any state:
  - state = IDLE, counter = 0;
  - `o_busy` = 0, `o_done` = 0, `o_sum` = 0, `o_carry` = 0, `o_ovf` = 0.
- Reset mid-operation aborts the operation with no `o_done`. Reset overrides `i_start` at the same edge.
- Start accepted at edge E0:
  - `o_busy` = 1 from E0 until edge E(N+1);
  - result and `o_done` become visible after edge EN, so latency is N clocks;
  - `o_done` is high for exactly the cycle between EN and E(N+1).
- Minimum start-to-start spacing is N+2 clocks. A start held high is accepted again at the first edge in IDLE, which is E(N+2).
- `o_busy` is registered and derived from state; there are no combinational input-to-output paths.

## Configuration
- `SERIAL_ADDER_SUB_EN` defined:
  - the `i_sub` port exists;
  - when the captured `i_sub` = 1, B is bitwise inverted at capture and the carry register is forced to 1, so `i_c` is ignored;
  - result = A − B. `o_carry` = 1 means no borrow. `o_ovf` is the signed-subtraction overflow.
- `SERIAL_ADDER_SUB_EN` not defined: no `i_sub` port and addition only. Behaviour is identical to the macro build with `i_sub` = 0.

## Test plan
- WIDTH=8, STEP=1: A=0x5A, B=0x33, c=0 → sum 0x8D, carry 0, ovf 1. `o_done` is high exactly 8 clocks after the start edge, for one cycle; `o_busy` spans 9 cycles.
- WIDTH=8, STEP=1: A=0xFF, B=0x01, c=1 → sum 0x01, carry 1, ovf 0. A second `i_start` pulse mid-RUN is ignored, with no extra `o_done`. The outputs hold afterwards.
- WIDTH=8, STEP=4: A=0xFF, B=0x01, c=0 → sum 0x00, carry 1, ovf 0, with `o_done` 2 clocks after the start edge. With `i_start` held high, the next acceptance is 4 clocks after the first.
- `SERIAL_ADDER_SUB_EN`, WIDTH=8: A=0x10, B=0x20, sub=1 → sum 0xF0, carry 0, ovf 0. A=0x80, B=0x01, sub=1 → sum 0x7F, carry 1, ovf 1.
- `i_rst_n` low for one edge at RUN digit 3: all outputs are 0, no `o_done`, and the block is in IDLE. A new start then completes normally.
- Randomised operands at WIDTH=16 and STEP ∈ {1, 2, 4, 8, 16}: sum, carry and ovf match a reference model.
